nibble_serial_adder_ctrl: RTL and testbench

Sequencer that performs WIDTH-bit add/subtract by time-sharing one 4-bit ripple-carry adder (ripple_adder_4bit, built from full_adder), one nibble per clock, LSB nibble first. Carry is held in a register between nibbles. Provides start/busy/done handshake for a host FSM. Targets datapaths where area matters more than latency.

---
 rtl/nibble_serial_adder_ctrl_pkg.sv | 12 +
 rtl/full_adder.sv | 13 +
 rtl/ripple_adder_4bit.sv | 26 ++
 rtl/nibble_serial_adder_ctrl.sv | 148 ++++++++++++++
 tb/tb_nibble_serial_adder_ctrl.sv | 200 ++++++++++++++++++++
 5 files changed

// File: rtl/nibble_serial_adder_ctrl_pkg.sv
// Shared types and constants for the nibble-serial add/subtract sequencer.
package nibble_serial_adder_ctrl_pkg;

    localparam int unsigned NIBBLE = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/full_adder.sv
// Single-bit full adder cell.
module full_adder (
    input  logic i_a,
    input  logic i_b,
    input  logic i_cin,
    output logic o_sum,
    output logic o_cout
);

    assign o_sum  = i_a ^ i_b ^ i_cin;
    assign o_cout = (i_a & i_b) | (i_cin & (i_a ^ i_b));

endmodule

// File: rtl/ripple_adder_4bit.sv
// 4-bit ripple-carry adder built from full_adder cells.
module ripple_adder_4bit (
    input  logic [3:0] i_a,
    input  logic [3:0] i_b,
    input  logic       i_cin,
    output logic [3:0] o_sum,
    output logic       o_cout
);

    logic [4:0] w_c;

    assign w_c[0] = i_cin;

    for (genvar g = 0; g < 4; g++) begin : g_bit
        full_adder u_fa (
            .i_a    (i_a[g]),
            .i_b    (i_b[g]),
            .i_cin  (w_c[g]),
            .o_sum  (o_sum[g]),
            .o_cout (w_c[g+1])
        );
    end

    assign o_cout = w_c[4];

endmodule

// File: rtl/nibble_serial_adder_ctrl.sv
// WIDTH-bit add/subtract using one shared 4-bit adder, one nibble per clock,
// LSB nibble first, with start/busy/done handshake.
module nibble_serial_adder_ctrl
    import nibble_serial_adder_ctrl_pkg::*;
#(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             overflow
);

    localparam int unsigned NNIB  = WIDTH / NIBBLE;
    localparam int unsigned IDX_W = (NNIB > 1) ? $clog2(NNIB) : 1;

    state_t             r_state;
    state_t             w_state_nxt;
    logic               w_accept;
    logic               w_last;

    logic [IDX_W-1:0]   r_idx;
    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_b_eff;
    logic [WIDTH-1:0]   r_sum;
    logic               r_carry;
    logic               r_cout;
    logic               r_ovf;
    logic               r_busy;
    logic               r_done;

    logic [NIBBLE-1:0]  w_a_nib;
    logic [NIBBLE-1:0]  w_b_nib;
    logic [NIBBLE-1:0]  w_sum_nib;
    logic               w_cout_nib;

    assign w_last = (r_idx == IDX_W'(NNIB - 1));

    // Select the current nibble of the latched operands.
    always_comb begin
        w_a_nib = '0;
        w_b_nib = '0;
        for (int unsigned n = 0; n < NNIB; n++) begin
            if (r_idx == IDX_W'(n)) begin
                w_a_nib = r_a[n*NIBBLE +: NIBBLE];
                w_b_nib = r_b_eff[n*NIBBLE +: NIBBLE];
            end
        end
    end

    ripple_adder_4bit u_adder (
        .i_a    (w_a_nib),
        .i_b    (w_b_nib),
        .i_cin  (r_carry),
        .o_sum  (w_sum_nib),
        .o_cout (w_cout_nib)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_accept    = 1'b1;
                    w_state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                if (w_last) begin
                    w_state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Operand latch, per-nibble writeback and final flag capture.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_idx   <= '0;
            r_a     <= '0;
            r_b_eff <= '0;
            r_sum   <= '0;
            r_carry <= 1'b0;
            r_cout  <= 1'b0;
            r_ovf   <= 1'b0;
        end else if (w_accept) begin
            r_idx   <= '0;
            r_a     <= a;
            r_b_eff <= sub ? ~b : b;
            r_sum   <= '0;
            r_carry <= sub ? 1'b1 : cin;
        end else if (r_state == ST_RUN) begin
            for (int unsigned n = 0; n < NNIB; n++) begin
                if (r_idx == IDX_W'(n)) begin
                    r_sum[n*NIBBLE +: NIBBLE] <= w_sum_nib;
                end
            end
            r_carry <= w_cout_nib;
            if (w_last) begin
                r_cout <= w_cout_nib;
                r_ovf  <= (r_a[WIDTH-1] == r_b_eff[WIDTH-1]) &&
                          (w_sum_nib[NIBBLE-1] != r_a[WIDTH-1]);
            end else begin
                r_idx <= r_idx + IDX_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_busy <= 1'b0;
            r_done <= 1'b0;
        end else begin
            r_busy <= (w_state_nxt == ST_RUN);
            r_done <= (w_state_nxt == ST_DONE);
        end
    end

    assign busy     = r_busy;
    assign done     = r_done;
    assign sum      = r_sum;
    assign cout     = r_cout;
    assign overflow = r_ovf;

endmodule

// File: tb/tb_nibble_serial_adder_ctrl.sv
// Randomized self-checking bench for nibble_serial_adder_ctrl (WIDTH=16).
module tb_nibble_serial_adder_ctrl;

    localparam int unsigned WIDTH = 16;
    localparam int unsigned NNIB  = WIDTH / 4;

    logic             clk = 1'b0;
    logic             reset;
    logic             start;
    logic             sub;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             overflow;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    nibble_serial_adder_ctrl #(.WIDTH(WIDTH)) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .sub      (sub),
        .a        (a),
        .b        (b),
        .cin      (cin),
        .busy     (busy),
        .done     (done),
        .sum      (sum),
        .cout     (cout),
        .overflow (overflow)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference: integer arithmetic on the operand values; returns {ovf, cout, sum}.
    function automatic logic [WIDTH+1:0] ref_op(input logic s, input logic [WIDTH-1:0] x,
                                                input logic [WIDTH-1:0] y, input logic ci);
        int          sx;
        int          sy;
        int          sres;
        logic [31:0] ures;
        logic        co;
        logic        ov;
        sx = int'($signed(x));
        sy = int'($signed(y));
        if (s) begin
            ures = 32'(x) - 32'(y);
            co   = (x >= y);
            sres = sx - sy;
        end else begin
            ures = 32'(x) + 32'(y) + 32'(ci);
            co   = (ures >= 32'(1 << WIDTH));
            sres = sx + sy + int'(ci);
        end
        ov = (sres > 32767) || (sres < -32768);
        return {ov, co, ures[WIDTH-1:0]};
    endfunction

    // One operation: latency, busy length, result, flags and one-cycle done.
    task automatic do_op(input logic s, input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                         input logic ci, input bit noise);
        logic [WIDTH+1:0] exp;
        int               n;
        int               busy_cnt;
        exp = ref_op(s, x, y, ci);
        @(negedge clk);
        start = 1'b1; sub = s; a = x; b = y; cin = ci;
        @(posedge clk); #1;
        start = 1'b0;
        a = WIDTH'($urandom); b = WIDTH'($urandom); cin = 1'($urandom); sub = 1'($urandom);
        n = 1;
        busy_cnt = 0;
        while (!done && n < 20) begin
            if (busy) busy_cnt++;
            if (noise) begin
                start = 1'($urandom); a = WIDTH'($urandom); b = WIDTH'($urandom);
            end
            @(posedge clk); #1;
            n++;
        end
        check("done_latency", 32'(n), 32'(NNIB + 1));
        check("busy_cycles", 32'(busy_cnt), 32'(NNIB));
        check("busy_in_done", 32'(busy), 32'd0);
        check("sum", 32'(sum), 32'(exp[WIDTH-1:0]));
        check("cout", 32'(cout), 32'(exp[WIDTH]));
        check("overflow", 32'(overflow), 32'(exp[WIDTH+1]));
        if (noise) begin
            start = 1'b1; a = 16'h0001; b = 16'h0001;
        end
        @(posedge clk); #1;
        start = 1'b0;
        check("done_pulse_width", 32'(done), 32'd0);
        if (noise) begin
            @(posedge clk); #1;
            check("no_queued_start", 32'(busy), 32'd0);
            check("retained_sum", 32'(sum), 32'(exp[WIDTH-1:0]));
        end
    endtask

    initial begin
        int               n;
        int               dones;
        int               gap;
        int               last_done;
        logic [WIDTH+1:0] r;
        reset = 1'b1; start = 1'b0; sub = 1'b0; a = '0; b = '0; cin = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_sum", 32'(sum), 32'd0);
        check("rst_cout", 32'(cout), 32'd0);
        check("rst_ovf", 32'(overflow), 32'd0);
        @(negedge clk);
        reset = 1'b0;

        // Directed corner cases, expected values from the reference model.
        do_op(1'b0, 16'h1234, 16'h0FFF, 1'b0, 1'b0);
        do_op(1'b0, 16'hFFFF, 16'h0001, 1'b0, 1'b0);
        do_op(1'b1, 16'h8000, 16'h0001, 1'b0, 1'b0);
        do_op(1'b1, 16'h0003, 16'h0005, 1'b0, 1'b0);
        do_op(1'b0, 16'h7FFF, 16'h0000, 1'b1, 1'b1);

        // Sanity of the reference on the documented vectors.
        r = ref_op(1'b0, 16'h1234, 16'h0FFF, 1'b0);
        check("ref_2233", 32'(r), 32'h0_2233);
        r = ref_op(1'b1, 16'h8000, 16'h0001, 1'b0);
        check("ref_7fff", 32'(r), 32'h3_7FFF);

        for (int i = 0; i < 40; i++) begin
            do_op(1'($urandom), WIDTH'($urandom), WIDTH'($urandom), 1'($urandom), (i % 5) == 0);
        end

        // Asynchronous reset two cycles into RUN discards the operation.
        @(negedge clk);
        start = 1'b1; sub = 1'b0; a = 16'h1111; b = 16'h2222; cin = 1'b0;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #3;
        reset = 1'b1;
        #1;
        check("arst_busy", 32'(busy), 32'd0);
        check("arst_done", 32'(done), 32'd0);
        check("arst_sum", 32'(sum), 32'd0);
        check("arst_cout", 32'(cout), 32'd0);
        check("arst_ovf", 32'(overflow), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        dones = 0;
        repeat (8) begin
            @(posedge clk); #1;
            if (done) dones++;
        end
        check("arst_no_done", 32'(dones), 32'd0);
        do_op(1'b0, 16'h00F0, 16'h0010, 1'b0, 1'b0);

        // Continuous start: done every NNIB+2 cycles, operand churn mid-RUN ignored.
        @(negedge clk);
        start = 1'b1; sub = 1'b0; a = 16'h0001; b = 16'h0002; cin = 1'b0;
        dones = 0;
        last_done = -1;
        n = 0;
        while (dones < 5 && n < 100) begin
            @(posedge clk); #1;
            n++;
            if (done) begin
                check("hold_sum", 32'(sum), 32'h0003);
                if (last_done >= 0) begin
                    gap = n - last_done;
                    check("hold_period", 32'(gap), 32'(NNIB + 2));
                end
                last_done = n;
                dones++;
                a = 16'h0001; b = 16'h0002; cin = 1'b0; sub = 1'b0;
            end else if (busy) begin
                a = WIDTH'($urandom); b = WIDTH'($urandom);
                cin = 1'($urandom); sub = 1'($urandom);
            end
        end
        check("hold_done_count", 32'(dones), 32'd5);
        start = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
